fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch stage feeding the decoder from a multi-cycle instruction memory.
//  Issues sequential word fetches over a req/ack handshake and buffers returned words with their PCs in a FIFO.
//  Presents the FIFO head to the decoder with a valid/ready handshake.
//  On redirect (taken branch/jump from the branch unit), flushes all buffered words and restarts fetch at the new PC.
// PARAMETERS
//  DEPTH     4             FIFO entries (power of 2, >=2); also bounds buffered + outstanding fetches
//  RESET_PC  32'h00000000  first fetch address after reset (word aligned)
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  RST          in   1   reset, asynchronous, active-high
//  mem_req      out  1   fetch request to instruction memory (registered)
//  mem_addr     out  32  fetch address, word aligned (registered)
//  mem_ack      in   1   memory returns mem_rdata for the held request this cycle
//  mem_rdata    in   32  instruction word, valid only when mem_ack=1
//  inst_valid   out  1   FIFO head is valid
//  inst         out  32  FIFO head instruction
//  inst_pc      out  32  PC of FIFO head instruction
//  inst_ready   in   1   decoder consumes head this cycle when inst_valid=1
//  redirect     in   1   flush and restart fetch
//  redirect_pc  in   32  new fetch PC; bits[1:0] ignored (forced 2'b00)
// BEHAVIOUR
//  Reset (async, RST=1):
//  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, state=IDLE.
//  - FIFO count=0, pointers=0, storage=0, so inst_valid=0, inst=0, inst_pc=0.
//  Handshake rules:
//  - At most one request outstanding.
//  - mem_req/mem_addr held stable from assertion until the cycle mem_ack=1.
//  - mem_ack with mem_req=0 is ignored.
//  - pop = inst_valid & inst_ready.
//  - inst/inst_pc = head entry, combinational from FIFO storage.
//  - inst_valid = (count!=0).
//  States:
//  - IDLE: no request outstanding.
//  - WAIT: request to mem_addr outstanding, data is kept.
//  - DISCARD: request outstanding, data will be dropped (stale after redirect).
//  Issue condition: space = (count_next < DEPTH).
//  - count_next = count + push - pop, or 0 when redirect.
//  - IDLE & space -> WAIT at next edge; mem_req=1, mem_addr=fetch_pc.
//  - Otherwise remain IDLE.
//  - First request is visible one cycle after RST deasserts.
//  WAIT & mem_ack & !redirect:
//  - push {mem_addr, mem_rdata}; fetch_pc = mem_addr + 4.
//  - If space, go back-to-back: stay WAIT with mem_addr = mem_addr+4, mem_req held 1.
//  - Else go IDLE, mem_req=0.
//  WAIT & !mem_ack: hold.
//  Redirect (highest priority, same cycle):
//  - FIFO flushed (count=0, pointers=0); any pop/push that cycle suppressed.
//  - fetch_pc = {redirect_pc[31:2],2'b00}.
//  - IDLE, or WAIT with mem_ack=1 (returned word dropped): next state WAIT, mem_req=1, mem_addr=new PC (1-cycle latency).
//  - WAIT with mem_ack=0: -> DISCARD; mem_req/mem_addr stay at old request.
//  DISCARD:
//  - On mem_ack: drop data; go to WAIT with mem_addr=fetch_pc (mem_req stays 1).
//  - Redirect in DISCARD only updates fetch_pc.
//  Simultaneous push and pop: both occur, count unchanged.
//  - Full FIFO can never be pushed, because issue requires space.
//  PC arithmetic: 32-bit, wraps 32'hFFFFFFFC -> 32'h00000000.
//  Assertion of RST mid-request: everything returns to reset values.
//  - A late mem_ack after reset is ignored (mem_req=0).
// TESTING
//  T1 reset release, mem_ack one cycle after each req, inst_ready=1:
//     -> mem_addr 0,4,8,... back-to-back; inst_pc/inst stream in order; no gaps after fill.
//  T2 inst_ready=0, DEPTH=4:
//     -> exactly 4 words buffered, mem_req=0.
//     -> 1 pop reissues at next PC within 1 cycle.
//     -> count never exceeds 4.
//  T3 redirect_pc=32'h100 while WAIT, ack 3 cycles later:
//     -> FIFO empty immediately; stale word dropped.
//     -> next req addr 32'h100; first inst_pc=32'h100.
//  T4 redirect coincident with mem_ack and pop, redirect_pc=32'h203:
//     -> word dropped, count=0, next mem_addr=32'h200.
//  T5 RESET_PC=32'hFFFFFFF8, free-running:
//     -> fetch addrs FFFFFFF8, FFFFFFFC, 00000000.
//  T6 RST pulsed mid-request with mem_ack arriving after:
//     -> outputs at reset values; ack ignored; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: issues sequential word fetches to a multi-cycle
// instruction memory over a req/ack handshake, buffers returned words with
// their PCs in a small FIFO and presents the head to the decoder. A redirect
// flushes everything buffered and restarts fetch at the new PC.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // WAIT keeps the returning word; DISCARD drops it (request predates a redirect)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        inst_mem_d [DEPTH];
    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        pc_mem_d   [DEPTH];

    logic               push;
    logic               pop;
    logic               space;
    logic [31:0]        new_pc;
    logic [31:0]        addr_inc;
    logic               unused_pc_lsbs;

    assign new_pc         = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign addr_inc       = mem_addr_q + 32'd4;

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

    // FIFO bookkeeping; a redirect wins over any push or pop in the same cycle
    always_comb begin
        push       = (state_q == WAIT) && mem_ack && !redirect;
        pop        = inst_valid && inst_ready && !redirect;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
        end
        if (push) begin
            inst_mem_d[wr_ptr_q] = mem_rdata;
            pc_mem_d[wr_ptr_q]   = mem_addr_q;
        end
        // At most one fetch is ever in flight, so room after this cycle's
        // updates guarantees room when the next word lands.
        space = (count_d < CNT_W'(DEPTH));
    end

    // Fetch FSM: request issue, back-to-back streaming and redirect handling
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = new_pc;
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = new_pc;
                end else if (space) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = new_pc;
                    if (mem_ack) begin
                        mem_addr_d = new_pc;
                    end else begin
                        // request must stay stable until acked; drop its data later
                        state_d = DISCARD;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = addr_inc;
                    if (space) begin
                        mem_addr_d = addr_inc;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = new_pc;
                end
                if (mem_ack) begin
                    state_d    = WAIT;
                    mem_addr_d = redirect ? new_pc : fetch_pc_q;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, handshake and FIFO registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory responder with programmable latency, a
// scoreboard of expected PCs filled by the stimulus and a monitor that checks
// every word the decoder consumes.
module tb_fetch_queue;

    logic        CLK;
    logic        RST;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          checks   = 0;
    int          failures = 0;
    int          pop_cnt  = 0;
    int          lat      = 1;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] log_q [$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // memory contents: each word is derived from its address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_pops(input int n, input int bound, input string name);
        int target;
        int k;
        target = pop_cnt + n;
        k = 0;
        while (pop_cnt < target && k < bound) begin
            step();
            k++;
        end
        checks++;
        if (pop_cnt < target) begin
            failures++;
            $display("FAIL %s actual_pops=%0d required_pops=%0d", name, pop_cnt - target + n, n);
        end
    endtask

    // memory responder: acks after 'lat' cycles of a held request
    always @(posedge CLK) begin
        #1;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = word_at(mem_addr);
            wait_cnt  = 0;
        end else if (!RST && mem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = word_at(mem_addr);
                log_q.push_back(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            wait_cnt  = 0;
        end
    end

    // monitor: every consumed head must match the scoreboard front
    always @(negedge CLK) begin
        if (!RST && !redirect && inst_valid && inst_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual_pc=%h required=none", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check32("pop_pc", inst_pc, e);
                check32("pop_inst", inst, word_at(e));
            end
        end
    end

    initial begin
        int   base;
        logic found;
        RST = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();

        // reset state
        check32("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rst_inst", inst, 32'h0);
        check32("rst_inst_pc", inst_pc, 32'h0);

        // T1: streaming from reset, ack one cycle after each request
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(4 * i));
        log_q.delete();
        inst_ready = 1'b1;
        base = pop_cnt;
        RST = 1'b0;
        step();
        check32("t1_first_req", {31'b0, mem_req}, 32'd1);
        check32("t1_first_addr", mem_addr, 32'h0);
        repeat (16) step();
        check32("t1_pops_no_gaps", 32'(pop_cnt - base), 32'd15);
        for (int i = 0; i < 16; i++)
            check32("t1_req_addr", (i < log_q.size()) ? log_q[i] : 32'hxxxx_xxxx, 32'(4 * i));

        // T2: decoder stalls, FIFO fills to exactly DEPTH
        inst_ready = 1'b0;
        step();
        step();
        check32("t2_req_at_three", {31'b0, mem_req}, 32'd1);
        check32("t2_addr_at_three", mem_addr, 32'd72);
        step();
        check32("t2_full_req_off", {31'b0, mem_req}, 32'd0);
        check32("t2_head_pc", inst_pc, 32'd60);
        check32("t2_head_inst", inst, word_at(32'd60));
        repeat (3) step();
        check32("t2_full_hold", {31'b0, mem_req}, 32'd0);
        check32("t2_full_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        step();
        check32("t2_reissue_req", {31'b0, mem_req}, 32'd1);
        check32("t2_reissue_addr", mem_addr, 32'd76);
        check32("t2_head_after_pop", inst_pc, 32'd64);
        inst_ready = 1'b0;
        step();
        check32("t2_refull_req_off", {31'b0, mem_req}, 32'd0);

        // T3: redirect while a slow request is outstanding
        lat = 3;
        inst_ready = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        step();
        redirect = 1'b0;
        check32("t3_flushed", {31'b0, inst_valid}, 32'd0);
        check32("t3_old_req_held", {31'b0, mem_req}, 32'd1);
        check32("t3_old_addr_held", mem_addr, 32'd80);
        step();
        check32("t3_discard_empty", {31'b0, inst_valid}, 32'd0);
        step();
        check32("t3_new_addr", mem_addr, 32'h0000_0100);
        check32("t3_new_req", {31'b0, mem_req}, 32'd1);
        check32("t3_stale_dropped", {31'b0, inst_valid}, 32'd0);
        wait_pops(1, 10, "t3_first_pop");

        // T4: redirect coincident with ack and pop, unaligned target
        lat = 1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (mem_ack && inst_valid) found = 1'b1;
            else step();
        end
        check32("t4_align", {31'b0, found}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        step();
        redirect = 1'b0;
        check32("t4_flushed", {31'b0, inst_valid}, 32'd0);
        check32("t4_req", {31'b0, mem_req}, 32'd1);
        check32("t4_aligned_addr", mem_addr, 32'h0000_0200);
        wait_pops(2, 10, "t4_pops");

        // T5: PC wrap through the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hFFFF_FFF8 + 32'(4 * i));
        step();
        redirect = 1'b0;
        wait_pops(4, 20, "t5_wrap_pops");

        // T6: reset mid-request, then a late ack with no request pending
        lat = 5;
        step();
        step();
        check32("t6_outstanding", {31'b0, mem_req}, 32'd1);
        RST = 1'b1;
        #1;
        check32("t6_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check32("t6_rst_mem_addr", mem_addr, 32'h0);
        check32("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
        check32("t6_rst_inst", inst, 32'h0);
        check32("t6_rst_inst_pc", inst_pc, 32'h0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        force_ack = 1'b1;
        step();
        RST = 1'b0;
        step();
        check32("t6_late_ack_ignored", {31'b0, inst_valid}, 32'd0);
        check32("t6_restart_req", {31'b0, mem_req}, 32'd1);
        check32("t6_restart_addr", mem_addr, 32'h0);
        force_ack = 1'b0;
        lat = 1;
        wait_pops(4, 20, "t6_restart_pops");

        inst_ready = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
